// File: rtl/signature_reader.sv
`default_nettype none
// ============================================================================
// Module   : signature_reader
// Brief    : Snoops the data-port store bus for the begin/end/exit marker
//            writes, then drains data memory begin..end (exclusive) word by
//            word onto a valid/ready stream through an asynchronous read port.
//            Optional macro SIG_CHECKSUM_EN adds a rotate-xor checksum of the
//            streamed words; when undefined, checksum is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module signature_reader #(
  parameter logic [31:0] BEGIN_ADDR = 32'h100,
  parameter logic [31:0] END_ADDR   = 32'h104,
  parameter logic [31:0] EXIT_ADDR  = 32'h108,
  parameter int unsigned MAX_WORDS  = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_we,
  input  logic [3:0]  st_mask,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        sig_valid,
  input  logic        sig_ready,
  output logic [31:0] sig_data,
  output logic        sig_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [31:0] C_WORD_BYTES = 32'd4;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_begin;
  logic [31:0] r_end;
  logic [31:0] r_ptr;
  logic [31:0] r_sig_data;
  logic        r_sig_last;
  logic        r_sig_valid;

  logic        w_exit;
  logic        w_bad;
  logic        w_empty;
  logic [31:0] w_len;
  logic        w_handshake;

  // The byte mask carries no information for marker decode.
  logic        w_unused;
  assign w_unused = ^st_mask;

  // Marker evaluation uses the begin/end values registered before the exit edge.
  assign w_exit      = (r_state == S_IDLE) && st_we && (st_addr == EXIT_ADDR);
  assign w_len       = (r_end - r_begin) >> 2;
  assign w_bad       = (r_begin[1:0] != 2'b00) || (r_end[1:0] != 2'b00) ||
                       (r_end < r_begin) || (w_len > MAX_WORDS);
  assign w_empty     = (r_end == r_begin);
  assign w_handshake = (r_state == S_SEND) && r_sig_valid && sig_ready;

  assign sig_valid = r_sig_valid;
  assign sig_data  = r_sig_data;
  assign sig_last  = r_sig_last;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_state_nxt = r_state;
    rd_addr     = 32'd0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_exit) begin
          if (w_bad) begin
            w_state_nxt = S_ERROR;
          end else if (w_empty) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        rd_addr     = r_ptr;
        busy        = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        busy = 1'b1;
        if (w_handshake) begin
          w_state_nxt = r_sig_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Marker capture, read pointer and the registered stream word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_begin     <= 32'd0;
      r_end       <= 32'd0;
      r_ptr       <= 32'd0;
      r_sig_data  <= 32'd0;
      r_sig_last  <= 1'b0;
      r_sig_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (st_we && (st_addr == BEGIN_ADDR)) begin
            r_begin <= st_wdata;
          end
          if (st_we && (st_addr == END_ADDR)) begin
            r_end <= st_wdata;
          end
          if (w_exit && !w_bad && !w_empty) begin
            r_ptr <= r_begin;
          end
        end
        S_FETCH: begin
          r_sig_data  <= rd_data;
          r_sig_last  <= ((r_ptr + C_WORD_BYTES) == r_end);
          r_sig_valid <= 1'b1;
        end
        S_SEND: begin
          if (w_handshake) begin
            r_sig_valid <= 1'b0;
            r_sig_last  <= 1'b0;
            if (!r_sig_last) begin
              r_ptr <= r_ptr + C_WORD_BYTES;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SIG_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Rotate-left-by-one then xor each accepted word; restarts from zero in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= 32'd0;
    end else if (r_state == S_IDLE) begin
      r_checksum <= 32'd0;
    end else if (w_handshake) begin
      r_checksum <= {r_checksum[30:0], r_checksum[31]} ^ r_sig_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/signature_reader.md
Name: signature_reader

Overview:
- Hardware counterpart to the test-signature convention of the data memory.
- Snoops the core's data-port store bus for the marker writes: begin address, end address, exit.
- On exit, takes over a dedicated asynchronous read port of the data memory, walks begin..end in word steps, and streams each word out on a valid/ready interface.
- Enables signature capture on FPGA/emulation, where file dumps are not available.

Parameters:
- BEGIN_ADDR, 'h100: store address whose data is latched as the signature begin address.
- END_ADDR, 'h104: store address whose data is latched as the signature end address (exclusive).
- EXIT_ADDR, 'h108: store address that triggers the drain.
- MAX_WORDS, 8192: largest legal signature length in words; equals the memory depth.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- st_we  in  1  data-port write enable (snooped).
- st_mask  in  4  data-port byte mask (snooped; ignored for marker decode).
- st_addr  in  32  data-port address (snooped).
- st_wdata  in  32  data-port write data (snooped).
- rd_addr  out  32  byte address to the memory read port.
- rd_data  in  32  word at rd_addr[31:2], combinational, same cycle.
- sig_valid  out  1  stream word valid.
- sig_ready  in  1  stream consumer ready.
- sig_data  out  32  stream word.
- sig_last  out  1  qualifies the final word, valid with sig_valid.
- busy  out  1  high in FETCH/SEND.
- done  out  1  drain completed normally; sticky.
- err  out  1  illegal markers at exit; sticky.
- checksum  out  32  see Optional Feature.

Behaviour:
- Reset: one clock, asynchronous active-low reset, rst_n, usable at any time.
  - Values on reset: state=IDLE; begin_q=end_q=ptr=0; sig_data=0; checksum=0; all 1-bit outputs 0; rd_addr=0.
  - Reset mid-drain aborts the stream immediately; no sig_last is issued.
- Marker snoop (IDLE only), on posedge clk with st_we=1:
  - st_addr==BEGIN_ADDR: begin_q<=st_wdata.
  - st_addr==END_ADDR: end_q<=st_wdata.
  - st_addr==EXIT_ADDR: evaluate markers and leave IDLE next cycle.
  - Full 32-bit address compare.
  - Marker stores in any state other than IDLE are ignored.
- Exit evaluation, using begin_q/end_q as registered before the exit edge:
  - begin_q[1:0]!=0, end_q[1:0]!=0, end_q<begin_q (unsigned), or (end_q-begin_q)>>2 > MAX_WORDS -> ERROR.
  - end_q==begin_q -> DONE with zero words streamed.
  - Exit without prior markers gives 0==0 -> DONE.
  - Otherwise ptr<=begin_q -> FETCH.
- States:
  - IDLE: rd_addr=0, sig_valid=0.
  - FETCH: rd_addr=ptr; sig_data<=rd_data; sig_last<=(ptr+4==end_q); sig_valid<=1; -> SEND.
  - SEND: sig_data, sig_last and sig_valid held stable until sig_ready=1.
    - On handshake with sig_last=1: sig_valid<=0, -> DONE.
    - On handshake otherwise: ptr<=ptr+4, sig_valid<=0, -> FETCH.
  - DONE: done=1, busy=0; terminal until reset.
  - ERROR: err=1; no stream activity; terminal until reset.
- Throughput and latency:
  - Exactly one word per 2 cycles when sig_ready is held 1.
  - First sig_valid rises 2 cycles after the exit edge.
- Arithmetic: ptr is a 32-bit unsigned increment and is never allowed to wrap, because end_q>=begin_q has been checked.
- Data coherency: the core is stalled or halted after exit; stores arriving during a drain are not forwarded and are outside this block's contract.

Optional Feature:
- Macro: SIG_CHECKSUM_EN.
- Defined:
  - checksum is a 32-bit register, cleared in IDLE.
  - On every stream handshake: checksum<=(checksum rotated left by 1) ^ sig_data.
  - Final value is stable in DONE.
- Undefined: checksum is tied to 0 and no register is inferred.

Test Plan:
- Store begin='h2000, end='h2010, exit; memory 'h2000..'h200C = 11,22,33,44; sig_ready=1 -> 4 words 11,22,33,44 on cycles 2,4,6,8 after exit; sig_last only on 44; done=1 after the last handshake.
- Same setup with sig_ready toggling 1-0-0-1 -> sig_data/sig_last stay stable while stalled; word order unchanged; no duplicate or skipped words.
- begin='h2002, end='h2010, exit -> err=1; sig_valid never rises; done=0. Repeat with end='h1000<begin -> err=1.
- Exit with no marker stores -> done=1 one cycle after exit; sig_valid never rises.
- Assert rst_n=0 mid-drain after the 2nd word -> all outputs 0 immediately; markers cleared; a fresh begin/end/exit sequence drains correctly.
- With SIG_CHECKSUM_EN, words 1,2 -> checksum = rotl(rotl(0)^1)^2 = 0 in DONE; words 'h80000000,1 -> checksum 0.
